edge_pixel_packer: RTL and testbench

- Consumer end of the edge-detect pixel stream.
- Accepts 4-bit magnitude pixels qualified by a valid strobe from the magnitude stage.
- Packs 8 pixels into one 32-bit word, buffers words in a small FIFO, and issues req/ack writes to the output frame buffer at incrementing addresses.
- Signals end of frame once every word of the frame has been written.

---
 rtl/edge_pixel_packer.sv | 179 +++++++++++++++++
 tb/tb_edge_pixel_packer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_pixel_packer.sv
// rtl/edge_pixel_packer.sv - packs 4-bit edge pixels into 32-bit words and writes them out via req/ack
// Optional build macro PACKER_THRESHOLD_EN adds a thresh input that zeroes pixels below it.
module edge_pixel_packer #(
    parameter int unsigned FRAME_PIXELS = 4096,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        frame_start,
    input  logic [3:0]  pixel,
    input  logic        pixel_valid,
`ifdef PACKER_THRESHOLD_EN
    input  logic [3:0]  thresh,
`endif
    output logic        write_req,
    output logic [31:0] write_addr,
    output logic [31:0] write_data,
    input  logic        write_ack,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow
);

    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   pix_cnt_q;
    logic [2:0]         nib_idx_q;
    logic [31:0]        word_q;
    logic               pend_q;
    logic [31:0]        pend_word_q;
    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     fifo_cnt_q;
    logic [PTR_W:0]     fifo_cnt_d;
    logic [31:0]        addr_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic [3:0]         pix_stored;
    logic               accept;
    logic               last_pix;
    logic               word_full;
    logic [31:0]        word_next;
    logic               pop;
    logic               full;
    logic               push_ok;
    logic               drop;

    always_comb begin
`ifdef PACKER_THRESHOLD_EN
        pix_stored = (pixel < thresh) ? 4'h0 : pixel;
`else
        pix_stored = pixel;
`endif
    end

    assign accept    = (state_q == S_ACTIVE) && pixel_valid;
    assign last_pix  = (pix_cnt_q == LAST_PIX);
    assign word_full = accept && ((nib_idx_q == 3'd7) || last_pix);
    assign word_next = word_q | ({28'h0, pix_stored} << {nib_idx_q, 2'b00});

    assign write_req  = (fifo_cnt_q != '0);
    assign write_data = write_req ? mem_q[rd_ptr_q] : 32'h0;
    assign write_addr = addr_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overflow   = ovf_q;

    // A completed word sits one cycle in pend_* before entering the FIFO;
    // a full FIFO still accepts it when the head pops in the same cycle.
    assign pop     = write_req && write_ack;
    assign full    = (fifo_cnt_q == FULL_CNT);
    assign push_ok = pend_q && (!full || pop);
    assign drop    = pend_q && full && !pop;

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push_ok && !pop) begin
            fifo_cnt_d = fifo_cnt_q + (PTR_W + 1)'(1);
        end else if (!push_ok && pop) begin
            fifo_cnt_d = fifo_cnt_q - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst && push_ok) begin
            mem_q[wr_ptr_q] <= pend_word_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            pix_cnt_q   <= '0;
            nib_idx_q   <= 3'd0;
            word_q      <= 32'h0;
            pend_q      <= 1'b0;
            pend_word_q <= 32'h0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            addr_q      <= BASE_ADDR;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pend_q     <= word_full;
            if (word_full) begin
                pend_word_q <= word_next;
            end
            fifo_cnt_q <= fifo_cnt_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                addr_q   <= addr_q + 32'd4;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        state_q   <= S_ACTIVE;
                        pix_cnt_q <= '0;
                        nib_idx_q <= 3'd0;
                        word_q    <= 32'h0;
                        ovf_q     <= 1'b0;
                        addr_q    <= BASE_ADDR;
                        busy_q    <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (accept) begin
                        pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                        if (word_full) begin
                            nib_idx_q <= 3'd0;
                            word_q    <= 32'h0;
                        end else begin
                            nib_idx_q <= nib_idx_q + 3'd1;
                            word_q    <= word_next;
                        end
                        if (last_pix) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if ((fifo_cnt_q == '0) && !pend_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_pixel_packer.sv
// tb/tb_edge_pixel_packer.sv - scoreboard bench for edge_pixel_packer
module tb_edge_pixel_packer;

    localparam int          FP    = 44;
    localparam int          FD    = 4;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [3:0]  THR   = 4'd4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        frame_start;
    logic [3:0]  pixel;
    logic        pixel_valid;
    logic        write_req;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic        write_ack;
    logic        busy;
    logic        frame_done;
    logic        overflow;
`ifdef PACKER_THRESHOLD_EN
    logic [3:0]  thresh = THR;
`endif

    edge_pixel_packer #(
        .FRAME_PIXELS(FP),
        .FIFO_DEPTH  (FD),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .frame_start(frame_start),
        .pixel      (pixel),
        .pixel_valid(pixel_valid),
`ifdef PACKER_THRESHOLD_EN
        .thresh     (thresh),
`endif
        .write_req  (write_req),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_ack  (write_ack),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          ack_mode = 0;
    logic [3:0]  frame_pix [$];
    logic [31:0] exp_words [$];
    logic [31:0] exp_data_q [$];
    logic [31:0] exp_addr_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] stored(input logic [3:0] p);
`ifdef PACKER_THRESHOLD_EN
        return (p < THR) ? 4'h0 : p;
`else
        return p;
`endif
    endfunction

    // Reference packing: pixel i goes to word i/8, nibble i%8; a short tail word keeps zeros.
    function automatic void build_words();
        exp_words.delete();
        for (int i = 0; i < frame_pix.size(); i++) begin
            if (i % 8 == 0) exp_words.push_back(32'h0);
            exp_words[exp_words.size() - 1] |= 32'(stored(frame_pix[i])) << (4 * (i % 8));
        end
    endfunction

    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0: write_ack = 1'b1;
            1: write_ack = ($urandom_range(0, 3) != 0);
            2: write_ack = 1'b0;
            default: ;
        endcase
    end

    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_rst = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] prev_data = 32'h0;

    always @(negedge clk) begin
        if (n_rst && prev_rst && prev_req && !prev_ack) begin
            chk("held_req", {31'h0, write_req}, 32'h1);
            chk("held_addr", write_addr, prev_addr);
            chk("held_data", write_data, prev_data);
        end
        if (n_rst && write_req && write_ack) begin
            if (exp_data_q.size() == 0) begin
                chk("unexpected_write_addr", write_addr, 32'hFFFF_FFFF);
            end else begin
                chk("write_data", write_data, exp_data_q.pop_front());
                chk("write_addr", write_addr, exp_addr_q.pop_front());
            end
        end
        prev_req  = write_req;
        prev_ack  = write_ack;
        prev_rst  = n_rst;
        prev_addr = write_addr;
        prev_data = write_data;
    end

    task automatic rand_pixels(input int first);
        for (int i = first; i < FP; i++) frame_pix.push_back(4'($urandom));
    endtask

    task automatic run_frame(input int gap_pct, input bit extra_start, input bit manual_ack,
                             input int keep, input bit exp_ovf, input bit lat_chk);
        int n;
        int seen;
        build_words();
        for (int w = 0; w < exp_words.size() && w < keep; w++) begin
            exp_data_q.push_back(exp_words[w]);
            exp_addr_q.push_back(BASE + 32'(4 * w));
        end
        frame_start = 1'b1;
        pixel_valid = 1'b1;
        pixel       = 4'($urandom);
        tick;
        frame_start = 1'b0;
        for (int i = 0; i < FP; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                pixel_valid = 1'b0;
                pixel       = 4'($urandom);
                tick;
            end
            pixel_valid = 1'b1;
            pixel       = frame_pix[i];
            frame_start = extra_start && (i == FP / 2);
            if (manual_ack) write_ack = (i + 1 >= 41);
            tick;
            if (lat_chk && i == 7) chk("lat_req_pending", {31'h0, write_req}, 32'h0);
            if (lat_chk && i == 8) begin
                chk("lat_req", {31'h0, write_req}, 32'h1);
                chk("lat_data", write_data, exp_words[0]);
                chk("lat_addr", write_addr, BASE);
            end
        end
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        if (manual_ack) ack_mode = 0;
        if (exp_ovf) begin
            repeat (5) tick;
            chk("ovf_set", {31'h0, overflow}, 32'h1);
            chk("ovf_req_held", {31'h0, write_req}, 32'h1);
            ack_mode = 0;
        end
        n = 0;
        seen = 0;
        while (n < 3000 && seen == 0) begin
            if (frame_done) seen = 1;
            else begin
                tick;
                n++;
            end
        end
        chk("frame_done_seen", 32'(seen), 32'h1);
        tick;
        chk("frame_done_pulse", {31'h0, frame_done}, 32'h0);
        chk("busy_after_done", {31'h0, busy}, 32'h0);
        chk("overflow_end", {31'h0, overflow}, {31'h0, exp_ovf});
        chk("writes_left", 32'(exp_data_q.size()), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        frame_start = 1'b0;
        pixel = 4'h0;
        pixel_valid = 1'b0;
        write_ack = 1'b1;
        repeat (3) tick;
        n_rst = 1'b1;
        tick;
        chk("rst_req", {31'h0, write_req}, 32'h0);
        chk("rst_addr", write_addr, BASE);
        chk("rst_data", write_data, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, frame_done}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);

        for (int i = 0; i < 5; i++) begin
            pixel_valid = 1'b1;
            pixel = 4'($urandom);
            tick;
        end
        pixel_valid = 1'b0;
        tick;
        chk("idle_ignores_req", {31'h0, write_req}, 32'h0);
        chk("idle_ignores_busy", {31'h0, busy}, 32'h0);

        frame_pix.delete();
        for (int i = 1; i <= 8; i++) frame_pix.push_back(4'(i));
        for (int i = 8; i >= 1; i--) frame_pix.push_back(4'(i));
        rand_pixels(16);
        ack_mode = 0;
        run_frame(0, 1'b0, 1'b0, 100, 1'b0, 1'b1);

        frame_pix.delete();
        rand_pixels(0);
        ack_mode = 1;
        run_frame(50, 1'b1, 1'b0, 100, 1'b0, 1'b0);

        frame_pix.delete();
        rand_pixels(0);
        ack_mode = 3;
        write_ack = 1'b0;
        run_frame(0, 1'b0, 1'b1, 100, 1'b0, 1'b0);

        frame_pix.delete();
        for (int i = 0; i < FP; i++) frame_pix.push_back(4'h3);
        ack_mode = 2;
        run_frame(0, 1'b0, 1'b0, FD, 1'b1, 1'b0);

        frame_pix.delete();
        rand_pixels(0);
        ack_mode = 2;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pixel_valid = 1'b1;
            pixel = frame_pix[i];
            tick;
        end
        pixel_valid = 1'b0;
        chk("midrst_pre_ovf", {31'h0, overflow}, 32'h0);
        chk("midrst_pre_busy", {31'h0, busy}, 32'h1);
        n_rst = 1'b0;
        tick;
        n_rst = 1'b1;
        exp_data_q.delete();
        exp_addr_q.delete();
        ack_mode = 0;
        tick;
        chk("midrst_req", {31'h0, write_req}, 32'h0);
        chk("midrst_addr", write_addr, BASE);
        chk("midrst_data", write_data, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_done", {31'h0, frame_done}, 32'h0);
        repeat (3) tick;
        chk("midrst_no_req", {31'h0, write_req}, 32'h0);

        for (int f = 0; f < 3; f++) begin
            frame_pix.delete();
            rand_pixels(0);
            ack_mode = (f == 0) ? 0 : 1;
            run_frame((f == 0) ? 0 : 30, 1'b0, 1'b0, 100, 1'b0, 1'b0);
        end

        repeat (3) tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
